// File: rtl/serv_lsu_ser.sv
// serv_lsu_ser: serial load/store unit for the SERV core.
// Bridges W-bit serial data to a 32-bit Wishbone data bus.
module serv_lsu_ser #(
  parameter int W        = 1,
  parameter bit WITH_CSR = 1'b1,
  parameter int TIMEOUT  = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req,
  output logic         o_ready,
  input  logic         i_we,
  input  logic         i_word,
  input  logic         i_half,
  input  logic         i_signed,
  input  logic [31:0]  i_addr,
  output logic         o_dat_req,
  input  logic [W-1:0] i_dat,
  output logic         o_rd_vld,
  output logic [W-1:0] o_rd,
  output logic         o_done,
  output logic         o_misalign,
  output logic         o_err,
  output logic [31:0]  o_wb_adr,
  output logic [31:0]  o_wb_dat,
  output logic [3:0]   o_wb_sel,
  output logic         o_wb_we,
  output logic         o_wb_cyc,
  input  logic [31:0]  i_wb_rdt,
  input  logic         i_wb_ack,
  input  logic         i_wb_err
);

  localparam int N  = 32 / W;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CLAST = CW'(N - 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_BUS,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]   dbuf;
  logic [31:0]   adr_q;
  logic          we_q;
  logic          word_q;
  logic          half_q;
  logic          sgn_q;
  logic          mis_q;
  logic          err_q;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;

  logic          misalign;
  logic          last;
  logic          tout;
  logic          bus_fail;
  logic [31:0]   rdt_sh;
  logic [31:0]   ld_ext;
  logic [3:0]    sel;

  assign misalign = WITH_CSR &
    ((i_addr[0] & (i_word | i_half)) |
     (i_addr[1] & i_word));

  assign last     = (cnt == CLAST);
  assign tout     = (TIMEOUT != 0) && (tcnt == TLAST);
  assign bus_fail = i_wb_err | (~i_wb_ack & tout);

  assign rdt_sh   = i_wb_rdt >> {adr_q[1:0], 3'b000};

  // load result: lane-aligned read data, sign/zero extended by size
  always_comb begin
    ld_ext = rdt_sh;
    if (!word_q && half_q)
      ld_ext = {{16{sgn_q & rdt_sh[15]}}, rdt_sh[15:0]};
    else if (!word_q)
      ld_ext = {{24{sgn_q & rdt_sh[7]}}, rdt_sh[7:0]};
  end

  // byte enables from access size and address offset
  always_comb begin
    sel = 4'b0001 << adr_q[1:0];
    if (word_q)
      sel = 4'b1111;
    else if (half_q)
      sel = 4'b0011 << adr_q[1:0];
  end

  assign o_wb_adr   = {adr_q[31:2], 2'b00};
  assign o_wb_dat   = dbuf << {adr_q[1:0], 3'b000};
  assign o_wb_sel   = o_wb_cyc ? sel : 4'b0000;
  assign o_wb_we    = o_wb_cyc & we_q;
  assign o_rd       = dbuf[W-1:0];
  assign o_misalign = o_done & mis_q;
  assign o_err      = o_done & err_q;

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_dat_req = 1'b0;
    o_rd_vld  = 1'b0;
    o_done    = 1'b0;
    o_wb_cyc  = 1'b0;
    unique case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_req) begin
          if (misalign)
            state_nxt = S_DONE;
          else if (i_we)
            state_nxt = S_FILL;
          else
            state_nxt = S_BUS;
        end
      end
      S_FILL: begin
        o_dat_req = 1'b1;
        if (last)
          state_nxt = S_BUS;
      end
      S_BUS: begin
        o_wb_cyc = 1'b1;
        if (bus_fail)
          state_nxt = S_DONE;
        else if (i_wb_ack)
          state_nxt = we_q ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        o_rd_vld = 1'b1;
        if (last)
          state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // request latch, shift buffer, shift and timeout counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dbuf   <= '0;
      adr_q  <= '0;
      we_q   <= 1'b0;
      word_q <= 1'b0;
      half_q <= 1'b0;
      sgn_q  <= 1'b0;
      mis_q  <= 1'b0;
      err_q  <= 1'b0;
      cnt    <= '0;
      tcnt   <= '0;
    end else begin
      if (state != S_BUS)
        tcnt <= '0;
      unique case (state)
        S_IDLE: begin
          if (i_req) begin
            adr_q  <= i_addr;
            we_q   <= i_we;
            word_q <= i_word;
            half_q <= i_half;
            sgn_q  <= i_signed;
            mis_q  <= misalign;
            err_q  <= 1'b0;
            cnt    <= '0;
          end
        end
        S_FILL: begin
          dbuf <= {i_dat, dbuf[31:W]};
          cnt  <= cnt + 1'b1;
        end
        S_BUS: begin
          tcnt <= tcnt + 1'b1;
          if (bus_fail)
            err_q <= 1'b1;
          else if (i_wb_ack && !we_q)
            dbuf <= ld_ext;
        end
        S_DRAIN: begin
          dbuf <= dbuf >> W;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_lsu_ser.sv
// tb_serv_lsu_ser: randomized scoreboard bench for serv_lsu_ser.
// Reference model predicts bus cycle, load value, flags, latency.
module tb_serv_lsu_ser;

  localparam int W  = 4;
  localparam int N  = 32 / W;
  localparam int TO = 5;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_req = 1'b0;
  logic         i_we = 1'b0;
  logic         i_word = 1'b0;
  logic         i_half = 1'b0;
  logic         i_signed = 1'b0;
  logic [31:0]  i_addr = '0;
  logic [W-1:0] i_dat = '0;
  logic [31:0]  i_wb_rdt = '0;
  logic         i_wb_ack = 1'b0;
  logic         i_wb_err = 1'b0;
  logic         o_ready;
  logic         o_dat_req;
  logic         o_rd_vld;
  logic [W-1:0] o_rd;
  logic         o_done;
  logic         o_misalign;
  logic         o_err;
  logic [31:0]  o_wb_adr;
  logic [31:0]  o_wb_dat;
  logic [3:0]   o_wb_sel;
  logic         o_wb_we;
  logic         o_wb_cyc;

  serv_lsu_ser #(.W(W), .WITH_CSR(1'b1), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req(i_req), .o_ready(o_ready),
    .i_we(i_we), .i_word(i_word), .i_half(i_half),
    .i_signed(i_signed), .i_addr(i_addr),
    .o_dat_req(o_dat_req), .i_dat(i_dat),
    .o_rd_vld(o_rd_vld), .o_rd(o_rd),
    .o_done(o_done), .o_misalign(o_misalign), .o_err(o_err),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat),
    .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
    .o_wb_cyc(o_wb_cyc), .i_wb_rdt(i_wb_rdt),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          abort;
    bit          mis;
    bit          err;
    bit          we;
    bit          ld;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdv;
    logic [3:0]  sel;
    int          bcyc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  int          rsp_d = 0;
  int          rsp_em = 0;
  int          fidx = 0;
  int          rbc = 0;
  logic [31:0] rsp_rdt = '0;
  logic [31:0] st_word = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] st_lane(logic [31:0] d, int a);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (i >= a) r[8*i +: 8] = d[8*(i-a) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] sel_model(int sz, int a);
    logic [3:0] s = '0;
    for (int i = 0; i < 4; i++)
      if (sz == 2 || i == a || (sz == 1 && i == a + 1))
        s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ld_model(int sz, int a, bit sgn,
                                           logic [31:0] rdt);
    logic [31:0] v;
    if (sz == 2) return rdt;
    if (sz == 1) begin
      v = {16'h0, rdt[8*a +: 16]};
      if (sgn && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = {24'h0, rdt[8*a +: 8]};
      if (sgn && v[7]) v = v | 32'hFFFFFF00;
    end
    return v;
  endfunction

  // bus slave and store-data source
  initial begin : resp
    forever begin
      @(posedge i_clk);
      #1;
      if (o_dat_req) begin
        i_dat = st_word[fidx*W +: W];
        fidx++;
      end else begin
        i_dat = '0;
      end
      if (o_wb_cyc) begin
        i_wb_ack = (rbc == rsp_d) && (rsp_em != 1);
        i_wb_err = (rbc == rsp_d) && (rsp_em != 0);
        i_wb_rdt = (rbc == rsp_d) ? rsp_rdt : $urandom;
        rbc++;
      end else begin
        rbc = 0;
        i_wb_ack = ($urandom % 4) == 0;
        i_wb_err = ($urandom % 8) == 0;
        i_wb_rdt = $urandom;
      end
    end
  end

  // monitor: compares DUT responses against queued expectations
  initial begin : mon
    bit          busy;
    int          t;
    int          mbc;
    int          rn;
    logic [31:0] racc;
    exp_t        e;
    busy = 0; t = 0; mbc = 0; rn = 0; racc = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        if (busy && q.size() > 0 && q[0].abort) q.delete(0);
        busy = 0;
      end else begin
        if (busy) t++;
        if (o_wb_cyc) begin
          if (mbc == 0) begin
            if (q.size() == 0) begin
              checks++; errors++;
              $display("FAIL bus_unexpected: cyc=1 want no access");
            end else begin
              chk("wb_adr", o_wb_adr, q[0].adr);
              chk("wb_sel", o_wb_sel, q[0].sel);
              chk("wb_we", o_wb_we, q[0].we);
              if (q[0].we) chk("wb_dat", o_wb_dat, q[0].dat);
            end
          end
          mbc++;
        end
        if (o_rd_vld) begin
          racc = {o_rd, racc[31:W]};
          rn++;
        end
        if (o_done) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: done=1 want 0");
          end else begin
            e = q.pop_front();
            chk("latency", t, e.lat);
            chk("misalign", o_misalign, e.mis);
            chk("err", o_err, e.err);
            chk("bus_cycles", mbc, e.bcyc);
            if (e.ld) begin
              chk("load_value", racc, e.rdv);
              chk("rd_beats", rn, N);
            end else begin
              chk("rd_beats", rn, 0);
            end
          end
          busy = 0;
        end
        if (i_req && o_ready) begin
          busy = 1; t = 0; mbc = 0; rn = 0;
        end
      end
    end
  end

  task automatic issue(bit we, int sz, logic [31:0] addr, bit sgn,
                       logic [31:0] data, logic [31:0] rdt,
                       int d, int em, bit abort);
    exp_t e;
    int   a;
    int   k;
    bit   tmo;
    @(posedge i_clk);
    #1;
    k = 0;
    while (!o_ready && k < 300) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    if (!o_ready) begin
      checks++; errors++;
      $display("FAIL ready_wait: o_ready=%0b want 1", o_ready);
      return;
    end
    a = int'(addr[1:0]);
    tmo = (d >= TO);
    e.abort = abort;
    e.we  = we;
    e.adr = {addr[31:2], 2'b00};
    e.mis = (sz == 2 && a != 0) || (sz == 1 && addr[0]);
    e.sel = sel_model(sz, a);
    e.dat = we ? st_lane(data, a) : 32'h0;
    e.err = !e.mis && (tmo || em != 0);
    e.bcyc = e.mis ? 0 : (tmo ? TO : d + 1);
    e.ld  = !we && !e.mis && !e.err;
    e.rdv = e.ld ? ld_model(sz, a, sgn, rdt) : 32'h0;
    e.lat = e.mis ? 1 :
      (we ? N : 0) + e.bcyc + 1 + (e.ld ? N : 0);
    st_word = data;
    fidx = 0;
    rsp_d = d;
    rsp_em = em;
    rsp_rdt = rdt;
    i_we = we;
    i_word = (sz == 2);
    i_half = (sz == 1);
    i_signed = sgn;
    i_addr = addr;
    i_req = 1'b1;
    q.push_back(e);
    @(posedge i_clk);
    #1;
    i_req = 1'b0;
    i_we = $urandom;
    i_word = $urandom;
    i_half = $urandom;
    i_signed = $urandom;
    i_addr = $urandom;
  endtask

  initial begin : drv
    int          k;
    int          sz;
    int          d;
    int          em;
    logic [31:0] addr;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_done", o_done, 0);
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_sel", o_wb_sel, 0);
    chk("rst_we", o_wb_we, 0);
    chk("rst_dat_req", o_dat_req, 0);
    chk("rst_rd_vld", o_rd_vld, 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_wb_dat", o_wb_dat, 0);
    chk("rst_wb_adr", o_wb_adr, 0);
    chk("rst_flags", {o_misalign, o_err}, 0);

    issue(1, 2, 32'h0000_0100, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    issue(0, 0, 32'h0000_0203, 1, 0, 32'h80123456, 0, 0, 0);
    issue(0, 0, 32'h0000_0203, 0, 0, 32'h80123456, 0, 0, 0);
    issue(1, 1, 32'h0000_1002, 0, 32'h0000ABCD, 0, 3, 0, 0);
    issue(0, 2, 32'h0000_0101, 0, 0, 32'h11111111, 0, 0, 0);
    issue(1, 1, 32'h0000_0033, 0, 32'h12345678, 0, 0, 0, 0);
    issue(0, 2, 32'h0000_0040, 0, 0, 32'h0, 7, 0, 0);
    issue(0, 1, 32'h0000_0042, 1, 0, 32'h8001_0000, 4, 0, 0);
    issue(1, 0, 32'h0000_0045, 0, 32'hA5, 0, 1, 2, 0);
    issue(1, 2, 32'h0000_0048, 0, 32'h0BADF00D, 0, 2, 1, 0);

    for (int n = 0; n < 80; n++) begin
      repeat ($urandom % 3) @(posedge i_clk);
      sz = $urandom % 3;
      addr = $urandom;
      if ($urandom % 5 != 0) begin
        if (sz == 2) addr[1:0] = 2'b00;
        if (sz == 1) addr[0] = 1'b0;
      end
      d = ($urandom % 6 == 0) ? TO + ($urandom % 3) : $urandom % TO;
      k = $urandom % 8;
      em = (k == 0) ? 1 : ((k == 1) ? 2 : 0);
      issue($urandom % 2, sz, addr, $urandom % 2,
            $urandom, $urandom, d, em, 0);
    end

    issue(0, 2, 32'h0000_0400, 0, 0, 32'h12345678, 20, 0, 1);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("rst_abort_cyc", o_wb_cyc, 0);
    chk("rst_abort_ready", o_ready, 1);
    repeat (5) @(posedge i_clk);
    issue(0, 1, 32'h0000_0402, 1, 0, 32'hF00D_1234, 1, 0, 0);

    k = 0;
    while (q.size() != 0 && k < 500) begin
      @(posedge i_clk);
      k++;
    end
    repeat (3) @(posedge i_clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serv_lsu_ser.md
# serv_lsu_ser

Parametrised load/store unit between the serial SERV datapath and a 32-bit Wishbone data bus. It accepts one access request at a time and checks alignment. Store data is deserialised W bits per cycle and placed into the correct byte lanes; load data is extracted, sign- or zero-extended and serialised back to the core W bits per cycle. It replaces the combinational memory-interface glue: buffering, bus handshake and bus-timeout handling all live in one block.

## Interface
Parameters:
- W, 1, bits transferred per cycle on the serial side (1, 2, 4 or 8); N = 32/W shift cycles per word.
- WITH_CSR, 1, when 1 misaligned accesses are reported and never reach the bus; when 0 the address low bits are ignored for alignment and the access is issued.
- TIMEOUT, 0, bus cycles to wait for an ack before aborting; 0 disables the timeout.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  1  access request; accepted when i_req & o_ready.
- o_ready  out  1  unit idle, can accept i_req.
- i_we  in  1  1 = store, 0 = load; sampled at acceptance.
- i_word, i_half  in  1  access size (neither = byte); sampled at acceptance.
- i_signed  in  1  sign-extend loads; sampled at acceptance.
- i_addr  in  32  byte address; sampled at acceptance.
- o_dat_req  out  1  store data wanted this cycle.
- i_dat  in  W  store data, LSB-first, sampled when o_dat_req.
- o_rd_vld  out  1  o_rd carries load data this cycle.
- o_rd  out  W  load data, LSB-first.
- o_done  out  1  one-cycle pulse; access finished (any outcome).
- o_misalign  out  1  qualifies o_done: access was misaligned, no bus cycle.
- o_err  out  1  qualifies o_done: bus error or timeout.
- o_wb_adr  out  32  word address, {addr[31:2],2'b00}.
- o_wb_dat  out  32  aligned store data.
- o_wb_sel  out  4  byte enables.
- o_wb_we  out  1  write strobe.
- o_wb_cyc  out  1  bus cycle active.
- i_wb_rdt  in  32  read data.
- i_wb_ack  in  1  cycle complete.
- i_wb_err  in  1  bus error, treated as completion with error.

## Operation
- States: IDLE, FILL, BUS, DRAIN, DONE.
- IDLE: o_ready=1. On acceptance, latch the control inputs and i_addr, and compute misalign = WITH_CSR & ((a[0] & (word|half)) | (a[1] & word)).
  - misalign → DONE with o_misalign.
  - store → FILL.
  - load → BUS.
- FILL: o_dat_req=1 for N cycles. Each cycle the buffer shifts right by W, with i_dat entering at bits [31:32-W]. After the Nth cycle → BUS.
- BUS: o_wb_cyc=1, o_wb_we=we.
  - o_wb_dat = buffer << 8*a[1:0]; higher bits are lost.
  - o_wb_sel: word = 4'b1111; half = 4'b0011 << a[1:0]; byte = 4'b0001 << a[1:0].
  - On i_wb_ack (and no i_wb_err): a load latches (i_wb_rdt >> 8*a[1:0]), extended from bit 7 (byte) or bit 15 (half) with sign if i_signed, else zero, then → DRAIN. A store → DONE.
  - On i_wb_err, or when TIMEOUT>0 and the cycle counter reaches TIMEOUT with no ack → DONE with o_err.
  - If ack and err arrive together, err wins.
- DRAIN: o_rd_vld=1 for N cycles, with o_rd = buffer[W-1:0]; the buffer shifts right by W each cycle. Then → DONE.
- DONE: o_done=1 for one cycle, with o_misalign/o_err as latched; → IDLE.
- o_wb_adr, o_wb_sel, o_wb_we and o_wb_dat are stable throughout BUS. o_wb_we and o_wb_sel are 0 outside BUS.

## Timing
- Reset values: state IDLE, o_ready=1, all other outputs 0, buffer and timeout counter 0.
- Reset mid-access aborts it: o_wb_cyc low the cycle after the reset edge, and no o_done is produced.
- Misaligned access: o_done/o_misalign in cycle 1 after acceptance; o_wb_cyc never asserts.
- Store latency: N FILL cycles, then ≥1 BUS cycle, then o_done on the cycle after ack. With zero-wait ack, total = N+2 cycles after acceptance.
- Load latency: ack at BUS cycle k, then o_rd_vld for the N cycles after ack, then o_done. With zero-wait ack, total = N+2 cycles.
- An ack in the first BUS cycle is legal.
- Timeout counter clears on BUS entry. The abort occurs on the cycle the count equals TIMEOUT; exactly TIMEOUT BUS cycles are observed.
- i_req is ignored whenever o_ready=0. A new request is accepted in the cycle after o_done.
- i_wb_ack/i_wb_err outside BUS are ignored.

## Test plan
- W=1, store word 0xDEADBEEF to 0x100, zero-wait ack → o_wb_adr=0x100, sel=1111, dat=0xDEADBEEF; o_done 34 cycles after acceptance.
- W=4, signed byte load from 0x203, i_wb_rdt=0x80123456 → 8 o_rd nibbles forming 0xFFFFFF80; then zero-extended repeat → 0x00000080.
- W=8, store half 0xABCD to 0x1002 → o_wb_sel=1100, o_wb_dat[31:16]=0xABCD, ack after 3 wait cycles → o_done 1 cycle after ack.
- WITH_CSR=1, word load at 0x101 → o_done+o_misalign in cycle 1, o_wb_cyc stays 0; WITH_CSR=0 same access → issued with sel=1111.
- TIMEOUT=5, no ack → o_wb_cyc high exactly 5 cycles, then o_done+o_err; ack and err in the same cycle → o_err=1.
- i_rst asserted in cycle 2 of BUS → o_wb_cyc=0 and o_ready=1 next cycle, no o_done; a following load completes normally.
